// File: rtl/voice_synth_pkg.sv
// Shared types and helpers for the voice mixer datapath.
package voice_synth_pkg;

  localparam int NUM_VOICES = 8;
  localparam int Q_FRAC     = 20;
  localparam int ONE_Q20    = 1 << Q_FRAC;

  typedef logic        [31:0]     phase_t;
  typedef logic signed [15:0]     sample_t;
  typedef logic signed [19:0]     mix_acc_t;
  typedef logic        [Q_FRAC:0] gain_t;    // 0 .. 1.0 in Q20

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_VOICE, ST_OUT} state_t;

  // Volume request -> gain target, limited to [0, 1.0]
  function automatic gain_t clamp_vol(input logic signed [31:0] v);
    if (v <= 0)            return '0;
    else if (v >= ONE_Q20) return gain_t'(ONE_Q20);
    else                   return gain_t'(v);
  endfunction

  // Mix bus -> 16-bit audio sample with saturation
  function automatic sample_t sat16(input mix_acc_t x);
    if (x > mix_acc_t'(32767))       return 16'sh7fff;
    else if (x < mix_acc_t'(-32768)) return 16'sh8000;
    else                             return sample_t'(x);
  endfunction

endpackage

// File: rtl/voice_gain.sv
// Combinational sawtooth * gain stage; gain limited to 1.0 so the
// contribution always fits 17 signed bits.
module voice_gain import voice_synth_pkg::*; (
  input  sample_t             wave,
  input  gain_t               env,
  output logic signed [16:0]  contrib
);

  gain_t              g;
  logic signed [37:0] prod;

  // Clamp gain, multiply, drop the Q20 fraction with floor rounding
  always_comb begin
    g       = (env > gain_t'(ONE_Q20)) ? gain_t'(ONE_Q20) : env;
    prod    = 38'(wave) * 38'($signed({1'b0, g}));
    contrib = 17'(prod >>> Q_FRAC);
  end

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed 8-voice sawtooth mixer: one voice per clock, one
// saturated 16-bit sample per accepted sample_tick.
// Optional feature macro: VOICE_MIXER_ENVELOPE_EN (linear gain slew).
module voice_mixer import voice_synth_pkg::*; #(
  parameter int SAMPLE_RATE = 48000,
  parameter int MIX_SHIFT   = 3,
  parameter int ENV_STEP    = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_tick,
  input  logic [NUM_VOICES-1:0][31:0]  frequencies,
  input  logic [NUM_VOICES-1:0][31:0]  voice_volumes,
  output sample_t                      audio_out,
  output logic                         audio_valid,
  output logic                         overrun
);

  // Hz (Q20) -> phase increment per sample, scaled for a 2^32 phase circle
  localparam logic [63:0] PHASE_K = (64'd1 << 32) / 64'(SAMPLE_RATE);

  state_t              state;
  logic [2:0]          vcnt;
  mix_acc_t            acc;
  phase_t              phase     [NUM_VOICES];
  logic signed [31:0]  freq_snap [NUM_VOICES];
  gain_t               tgt_snap  [NUM_VOICES];

`ifdef VOICE_MIXER_ENVELOPE_EN
  localparam gain_t ENV_STEP_Q = gain_t'(ENV_STEP);
  gain_t env [NUM_VOICES];
`else
  // Immediate gain build: still reject a nonsensical ENV_STEP override
  if (ENV_STEP <= 0) begin : g_bad_env_step
    $error("ENV_STEP must be positive");
  end
`endif

  logic signed [31:0]  f_cur;
  gain_t               tgt_cur;
  logic [63:0]         inc_prod;
  phase_t              inc;
  sample_t             wave;
  gain_t               gain;
  logic signed [16:0]  contrib;

  // Per-voice operands for the voice currently selected by vcnt
  always_comb begin
    f_cur    = freq_snap[vcnt];
    tgt_cur  = tgt_snap[vcnt];
    inc_prod = {{32{f_cur[31]}}, f_cur} * PHASE_K;
    inc      = (f_cur > 0) ? phase_t'(inc_prod >> Q_FRAC) : '0;
    wave     = $signed(phase[vcnt][31:16]);
`ifdef VOICE_MIXER_ENVELOPE_EN
    gain     = env[vcnt];
`else
    gain     = tgt_cur;
`endif
  end

  voice_gain u_gain (
    .wave    (wave),
    .env     (gain),
    .contrib (contrib)
  );

  // Sequencer: IDLE -> LOAD -> VOICE x8 -> OUT, plus per-voice state update
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      vcnt        <= '0;
      acc         <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i]     <= '0;
        freq_snap[i] <= '0;
        tgt_snap[i]  <= '0;
`ifdef VOICE_MIXER_ENVELOPE_EN
        env[i]       <= '0;
`endif
      end
    end else begin
      audio_valid <= 1'b0;
      if (sample_tick && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: if (sample_tick) state <= ST_LOAD;
        ST_LOAD: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            freq_snap[i] <= $signed(frequencies[i]);
            tgt_snap[i]  <= clamp_vol($signed(voice_volumes[i]));
          end
          acc   <= '0;
          vcnt  <= '0;
          state <= ST_VOICE;
        end
        ST_VOICE: begin
          // contribution uses pre-update phase/env; update follows
          acc         <= acc + mix_acc_t'(contrib);
          phase[vcnt] <= (f_cur > 0) ? phase[vcnt] + inc : '0;
`ifdef VOICE_MIXER_ENVELOPE_EN
          if (env[vcnt] < tgt_cur)
            env[vcnt] <= (tgt_cur - env[vcnt] > ENV_STEP_Q) ? env[vcnt] + ENV_STEP_Q : tgt_cur;
          else
            env[vcnt] <= (env[vcnt] - tgt_cur > ENV_STEP_Q) ? env[vcnt] - ENV_STEP_Q : tgt_cur;
`endif
          vcnt <= vcnt + 3'd1;
          if (vcnt == 3'(NUM_VOICES - 1)) state <= ST_OUT;
        end
        ST_OUT: begin
          audio_out   <= sat16(acc >>> MIX_SHIFT);
          audio_valid <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: two instances (MIX_SHIFT 3 and 0)
// share stimulus; a per-sample arithmetic model predicts every output.
module tb_voice_mixer;
  import voice_synth_pkg::*;

  localparam longint PK  = 89478;       // floor(2^32 / 48000)
  localparam longint ONE = 1 << 20;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        sample_tick = 1'b0;
  logic [NUM_VOICES-1:0][31:0] frequencies = '0;
  logic [NUM_VOICES-1:0][31:0] voice_volumes = '0;
  sample_t                     out_a, out_b;
  logic                        val_a, val_b, ovr_a, ovr_b;

  voice_mixer #(.MIX_SHIFT(3)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .frequencies(frequencies), .voice_volumes(voice_volumes),
    .audio_out(out_a), .audio_valid(val_a), .overrun(ovr_a));

  voice_mixer #(.MIX_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .frequencies(frequencies), .voice_volumes(voice_volumes),
    .audio_out(out_b), .audio_valid(val_b), .overrun(ovr_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  typedef struct { int cyc; longint s3; longint s0; } exp_t;
  exp_t   expq[$];
  longint mphase [NUM_VOICES];
  longint menv   [NUM_VOICES];
  longint held3 = 0, held0 = 0;
  int     ovr_from = -1;
  int     last_acc = 0;
  bit     have_acc = 0;
  int     n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic longint sat(input longint x);
    return (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
  endfunction

  // One whole sample from the arithmetic rules, advancing phases/envelopes
  function automatic void model_sample(output longint s3, output longint s0);
    longint acc, f, vol, tgt, g, w, inc;
    acc = 0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      f   = longint'($signed(frequencies[v]));
      vol = longint'($signed(voice_volumes[v]));
      tgt = (vol < 0) ? 0 : ((vol > ONE) ? ONE : vol);
`ifdef VOICE_MIXER_ENVELOPE_EN
      g = menv[v];
`else
      g = tgt;
`endif
      w = mphase[v] >> 16;
      if (w >= 32768) w = w - 65536;
      acc = acc + ((w * g) >>> 20);
      if (f > 0) begin
        inc       = ((f * PK) >> 20) & 64'hFFFF_FFFF;
        mphase[v] = (mphase[v] + inc) & 64'hFFFF_FFFF;
      end else begin
        mphase[v] = 0;
      end
      if (menv[v] < tgt) menv[v] = (menv[v] + 4096 > tgt) ? tgt : menv[v] + 4096;
      else               menv[v] = (menv[v] - 4096 < tgt) ? tgt : menv[v] - 4096;
    end
    s3 = sat(acc >>> 3);
    s0 = sat(acc);
  endfunction

  function automatic void model_clear();
    expq.delete();
    for (int v = 0; v < NUM_VOICES; v++) begin
      mphase[v] = 0;
      menv[v]   = 0;
    end
    held3 = 0; held0 = 0; ovr_from = -1; have_acc = 0;
  endfunction

  function automatic void model_tick();
    exp_t e;
    if (!have_acc || cyc >= last_acc + 11) begin
      have_acc = 1;
      last_acc = cyc;
      e.cyc = cyc + 11;
      model_sample(e.s3, e.s0);
      expq.push_back(e);
    end else if (ovr_from < 0) begin
      ovr_from = cyc + 1;
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    bit ev;
    bit eo;
    if (!reset) begin
      ev = (expq.size() > 0) && (expq[0].cyc == cyc);
      if (ev) begin
        held3 = expq[0].s3;
        held0 = expq[0].s0;
        void'(expq.pop_front());
      end
      eo = (ovr_from >= 0) && (cyc >= ovr_from);
      chk("valid_a", val_a, ev);
      chk("valid_b", val_b, ev);
      chk("out_a", out_a, held3);
      chk("out_b", out_b, held0);
      chk("overrun_a", ovr_a, eo);
      chk("overrun_b", ovr_b, eo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(1);
    model_clear();
    step(n - 1);
    reset = 1'b0;
  endtask

  task automatic do_tick(input int gap);
    sample_tick = 1'b1;
    model_tick();
    step(1);
    sample_tick = 1'b0;
    step(gap - 1);
  endtask

  task automatic set_all(input logic [31:0] f, input logic [31:0] vol);
    for (int v = 0; v < NUM_VOICES; v++) begin
      frequencies[v]   = f;
      voice_volumes[v] = vol;
    end
  endtask

  task automatic randomize_inputs();
    for (int v = 0; v < NUM_VOICES; v++) begin
      case ($urandom_range(0, 3))
        0: frequencies[v] = $urandom;
        1: frequencies[v] = 32'($urandom_range(1, 2047)) << 20;
        2: frequencies[v] = '0;
        default: frequencies[v] = 32'($urandom_range(0, 32'h7fff_ffff));
      endcase
      case ($urandom_range(0, 3))
        0: voice_volumes[v] = $urandom;
        1: voice_volumes[v] = 32'(ONE);
        2: voice_volumes[v] = 32'($urandom_range(0, 32'(ONE)));
        default: voice_volumes[v] = '0;
      endcase
    end
  endtask

  initial begin
    // 1: reset state and silent first sample
    do_reset(2);
    step(1);
    chk("rst_out", out_a, 0);
    chk("rst_valid", val_a, 0);
    chk("rst_overrun", ovr_a, 0);
    do_tick(20);
    chk("t1_first", out_a, 0);

    // 2: single 440 Hz voice at full volume
    do_reset(2);
    frequencies[0]   = 32'(440) << 20;
    voice_volumes[0] = 32'(ONE);
    do_tick(1000);
    chk("t2_s1", out_a, 0);
    do_tick(1000);
`ifndef VOICE_MIXER_ENVELOPE_EN
    chk("t2_s2", out_a, 75);
    chk("t2_model", held3, 75);
    // 5 (immediate gain): volume to zero silences the next sample
    voice_volumes[0] = '0;
    do_tick(20);
    chk("t5_mute", out_a, 0);
`else
    // 5 (envelope): ramp up, then release to zero over 256 samples
    repeat (300) do_tick(12);
    voice_volumes[0] = '0;
    repeat (257) do_tick(12);
    chk("t5_env_zero", out_a, 0);
    chk("t5_model", held3, 0);
`endif

    // 4: tick while busy, and tick during OUT
    do_reset(2);
    set_all(32'(100) << 20, 32'(ONE));
    do_tick(11);
    do_tick(11);
    chk("t4_spacing_ok", ovr_a, 0);
    do_tick(5);
    do_tick(20);
    chk("t4_busy", ovr_a, 1);
    do_reset(2);
    do_tick(10);
    do_tick(20);
    chk("t4_out_state", ovr_b, 1);

`ifndef VOICE_MIXER_ENVELOPE_EN
    // 3: eight near-max sawtooths saturate the unshifted mix
    do_reset(2);
    set_all(32'(2047) << 20, 32'(ONE));
    repeat (12) do_tick(12);
    chk("t3_sat", out_b, 32767);
    chk("t3_shift3", out_a, 30743);
`endif

    // 6: reset 5 clk after tick aborts the sample
    do_reset(2);
    set_all('0, '0);
    frequencies[0]   = 32'(440) << 20;
    voice_volumes[0] = 32'(ONE);
    do_tick(5);
    do_reset(2);
    step(20);
    chk("t6_noval_out", out_a, 0);
    do_tick(20);
    chk("t6_first", out_a, 0);
`ifndef VOICE_MIXER_ENVELOPE_EN
    do_tick(20);
    chk("t6_second", out_a, 75);
`endif

    // random: legal spacing, then mixed spacing with overruns
    do_reset(2);
    repeat (150) begin
      randomize_inputs();
      do_tick($urandom_range(11, 25));
    end
    do_reset(2);
    repeat (150) begin
      randomize_inputs();
      do_tick(($urandom_range(0, 7) == 0) ? $urandom_range(2, 10) : $urandom_range(11, 25));
    end

    step(20);
    chk("drain", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
